// File: rtl/nibble_serial_addsub_if.sv
// Handshake and data bundle for nibble_serial_addsub.
// The acc_sel request bit exists only when NSA_ACCUM_EN is defined.
interface nibble_serial_addsub_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic             op_sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
`ifdef NSA_ACCUM_EN
   logic             acc_sel;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             ovf_signed;
   logic             ovf_unsigned;

   // Requester side: issues operations, observes status and result
   modport master (
      output start, op_sub, a, b,
`ifdef NSA_ACCUM_EN
      output acc_sel,
`endif
      input  busy, done, result, cout, ovf_signed, ovf_unsigned
   );

   // Adder side: accepts operations, drives status and result
   modport slave (
      input  start, op_sub, a, b,
`ifdef NSA_ACCUM_EN
      input  acc_sel,
`endif
      output busy, done, result, cout, ovf_signed, ovf_unsigned
   );
endinterface

// File: rtl/nibble_serial_addsub.sv
// nibble_serial_addsub: WIDTH-bit add/subtract computed one nibble per clock
// through a single 4-bit slice, LSB nibble first, carry registered between
// nibbles. Subtraction is a + ~b + 1 (carry-in seeded with op_sub).
// Optional feature macro: NSA_ACCUM_EN (adds acc_sel; A operand may be taken
// from the current result register for chained accumulation).
module nibble_serial_addsub #(
   parameter int WIDTH = 16
) (
   input logic                   clk,
   input logic                   rst_n,
   nibble_serial_addsub_if.slave bus
);

   localparam int NIB   = WIDTH / 4;
   localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // 4-bit add slice: returns {carry_out, sum[3:0]}
   function automatic logic [4:0] slice_add(input logic [3:0] x,
                                            input logic [3:0] y,
                                            input logic       ci);
      slice_add = {1'b0, x} + {1'b0, y} + {4'b0000, ci};
   endfunction

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a;        // shifts right one nibble per RUN cycle
   logic [WIDTH-1:0] r_b;        // already inverted for subtraction
   logic             r_op_sub;
   logic             r_carry;
   logic [IDX_W-1:0] r_idx;
   logic [WIDTH-1:0] r_result;
   logic             r_busy;
   logic             r_done;
   logic             r_cout;
   logic             r_ovf_s;
   logic             r_ovf_u;

   logic             w_accept;
   logic [WIDTH-1:0] w_a_src;
   logic [WIDTH-1:0] w_b_src;
   logic [4:0]       w_slice;
   logic             w_last;
   logic [WIDTH-1:0] w_result_next;

   // Request acceptance, operand source selection and the nibble slice
   always_comb begin
      w_accept      = 1'b0;
      w_a_src       = bus.a;
      w_b_src       = bus.b;
      w_result_next = r_result;
      if (((r_state == S_IDLE) || (r_state == S_DONE)) && bus.start) begin
         w_accept = 1'b1;
      end else begin
         w_accept = 1'b0;
      end
`ifdef NSA_ACCUM_EN
      if (bus.acc_sel) begin
         w_a_src = r_result;
      end else begin
         w_a_src = bus.a;
      end
`endif
      if (bus.op_sub) begin
         w_b_src = ~bus.b;
      end else begin
         w_b_src = bus.b;
      end
      w_slice = slice_add(r_a[3:0], r_b[3:0], r_carry);
      w_last  = (r_idx == LAST_IDX);
      for (int n = 0; n < NIB; n++) begin
         if (r_idx == IDX_W'(n)) begin
            w_result_next[4*n +: 4] = w_slice[3:0];
         end else begin
            w_result_next[4*n +: 4] = r_result[4*n +: 4];
         end
      end
   end

   // Sequencer: IDLE -> RUN (NIB nibbles) -> DONE, DONE may re-enter RUN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_op_sub <= 1'b0;
         r_carry  <= 1'b0;
         r_idx    <= '0;
         r_result <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_cout   <= 1'b0;
         r_ovf_s  <= 1'b0;
         r_ovf_u  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               r_done <= 1'b0;
               if (w_accept) begin
                  r_a      <= w_a_src;
                  r_b      <= w_b_src;
                  r_op_sub <= bus.op_sub;
                  r_carry  <= bus.op_sub;
                  r_idx    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= S_RUN;
               end else begin
                  r_busy   <= 1'b0;
                  r_state  <= S_IDLE;
               end
            end
            S_RUN: begin
               r_result <= w_result_next;
               r_carry  <= w_slice[4];
               r_a      <= {4'b0000, r_a[WIDTH-1:4]};
               r_b      <= {4'b0000, r_b[WIDTH-1:4]};
               if (w_last) begin
                  // r_a[3]/r_b[3] hold the operand MSBs on the last nibble
                  r_cout  <= w_slice[4];
                  r_ovf_s <= (r_a[3] == r_b[3]) && (w_slice[3] != r_a[3]);
                  r_ovf_u <= r_op_sub ? ~w_slice[4] : w_slice[4];
                  r_idx   <= '0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_idx   <= r_idx + IDX_W'(1);
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
                  r_state <= S_RUN;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy         = r_busy;
   assign bus.done         = r_done;
   assign bus.result       = r_result;
   assign bus.cout         = r_cout;
   assign bus.ovf_signed   = r_ovf_s;
   assign bus.ovf_unsigned = r_ovf_u;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed self-checking bench for nibble_serial_addsub (WIDTH=16).
// Accumulation steps are compiled in only when NSA_ACCUM_EN is defined.
module tb_nibble_serial_addsub;

   localparam int WIDTH = 16;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   nibble_serial_addsub_if #(.WIDTH(WIDTH)) bus_if ();

   nibble_serial_addsub #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full operation: drive, accept, check busy window, done and flags
   task automatic op_check(input string tag, input logic [15:0] av, input logic [15:0] bv,
                           input logic sub, input logic acc, input logic [15:0] exp_res,
                           input logic exp_c, input logic exp_os, input logic exp_ou);
      @(negedge clk);
      bus_if.a      = av;
      bus_if.b      = bv;
      bus_if.op_sub = sub;
`ifdef NSA_ACCUM_EN
      bus_if.acc_sel = acc;
`endif
      bus_if.start  = 1'b1;
      @(negedge clk);
      bus_if.start  = 1'b0;
      bus_if.a      = ~av;
      bus_if.b      = ~bv;
      bus_if.op_sub = ~sub;
`ifdef NSA_ACCUM_EN
      bus_if.acc_sel = ~acc;
`endif
      for (int i = 0; i < 4; i++) begin
         check({tag, "_busy"}, {31'b0, bus_if.busy}, 32'd1);
         check({tag, "_nodone"}, {31'b0, bus_if.done}, 32'd0);
         @(negedge clk);
      end
      check({tag, "_done"}, {31'b0, bus_if.done}, 32'd1);
      check({tag, "_idle"}, {31'b0, bus_if.busy}, 32'd0);
      check({tag, "_result"}, {16'b0, bus_if.result}, {16'b0, exp_res});
      check({tag, "_cout"}, {31'b0, bus_if.cout}, {31'b0, exp_c});
      check({tag, "_ovfs"}, {31'b0, bus_if.ovf_signed}, {31'b0, exp_os});
      check({tag, "_ovfu"}, {31'b0, bus_if.ovf_unsigned}, {31'b0, exp_ou});
      @(negedge clk);
      check({tag, "_pulse"}, {31'b0, bus_if.done}, 32'd0);
   endtask

   logic [15:0] exp_chain [3];

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      bus_if.start  = 1'b0;
      bus_if.op_sub = 1'b0;
      bus_if.a      = 16'h0000;
      bus_if.b      = 16'h0000;
`ifdef NSA_ACCUM_EN
      bus_if.acc_sel = 1'b0;
`endif
      exp_chain[0] = 16'h0000;
      exp_chain[1] = 16'h050A;
      exp_chain[2] = 16'h0A14;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy", {31'b0, bus_if.busy}, 32'd0);
      check("rst_done", {31'b0, bus_if.done}, 32'd0);
      check("rst_result", {16'b0, bus_if.result}, 32'd0);
      check("rst_flags", {29'b0, bus_if.cout, bus_if.ovf_signed, bus_if.ovf_unsigned}, 32'd0);
      rst_n = 1'b1;

      // Additions and subtractions with boundary carries/overflows
      op_check("add1", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
      op_check("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      op_check("add_sovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
      op_check("sub_sovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
      op_check("sub_borrow", 16'h0003, 16'h0009, 1'b1, 1'b0, 16'hFFFA, 1'b0, 1'b0, 1'b1);

      // Start held high with operands changing every cycle: back-to-back ops
      @(negedge clk);
      bus_if.op_sub = 1'b0;
      bus_if.start  = 1'b1;
      for (int k = 0; k < 15; k++) begin
         bus_if.a = {k[7:0], k[7:0]};
         bus_if.b = {8'h00, k[7:0]};
         @(negedge clk);
         check("b2b_busy", {31'b0, bus_if.busy}, {31'b0, (k % 5) != 4});
         check("b2b_done", {31'b0, bus_if.done}, {31'b0, (k % 5) == 4});
         if ((k % 5) == 4) begin
            check("b2b_result", {16'b0, bus_if.result}, {16'b0, exp_chain[k/5]});
         end else begin
            tests = tests;
         end
      end
      bus_if.start = 1'b0;

      // A start pulse in mid-RUN is ignored
      @(negedge clk);
      bus_if.a = 16'h1111;
      bus_if.b = 16'h2222;
      bus_if.start = 1'b1;
      @(negedge clk);
      bus_if.start = 1'b0;
      @(negedge clk);
      bus_if.a = 16'hAAAA;
      bus_if.start = 1'b1;
      @(negedge clk);
      bus_if.start = 1'b0;
      @(negedge clk);
      check("midrun_busy", {31'b0, bus_if.busy}, 32'd1);
      @(negedge clk);
      check("midrun_done", {31'b0, bus_if.done}, 32'd1);
      check("midrun_result", {16'b0, bus_if.result}, 32'h3333);
      @(negedge clk);
      check("midrun_noreissue", {30'b0, bus_if.busy, bus_if.done}, 32'd0);

      // Async reset two cycles into RUN, after a borrow left flags set
      op_check("pre_rst", 16'h0003, 16'h0009, 1'b1, 1'b0, 16'hFFFA, 1'b0, 1'b0, 1'b1);
      bus_if.a = 16'h1234;
      bus_if.b = 16'h1111;
      bus_if.op_sub = 1'b0;
      bus_if.start = 1'b1;
      @(negedge clk);
      bus_if.start = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", {31'b0, bus_if.busy}, 32'd0);
      check("arst_result", {16'b0, bus_if.result}, 32'd0);
      check("arst_flags", {29'b0, bus_if.cout, bus_if.ovf_signed, bus_if.ovf_unsigned}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("arst_nodone", {30'b0, bus_if.busy, bus_if.done}, 32'd0);
      end
      op_check("post_rst", 16'h0004, 16'h0005, 1'b0, 1'b0, 16'h0009, 1'b0, 1'b0, 1'b0);

`ifdef NSA_ACCUM_EN
      // Chained accumulation: result = result +/- b
      op_check("acc_base", 16'h0005, 16'h0003, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0);
      op_check("acc_add", 16'hF00D, 16'h0002, 1'b0, 1'b1, 16'h000A, 1'b0, 1'b0, 1'b0);
      op_check("acc_sub", 16'hBEEF, 16'h000B, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
